// File: rtl/n64_vbus_tx_pkg.sv
// Shared constants for the N64 video bus transmitter: bus geometry, slot
// phase encodings, run states and the position of the sync nibble in a pixel.
package n64_vbus_tx_pkg;

    localparam int COLOR_WIDTH_DEF = 7;
    localparam int SYNC_W          = 4;

    localparam logic [1:0] PH_SYNC = 2'd0;
    localparam logic [1:0] PH_R    = 2'd1;
    localparam logic [1:0] PH_G    = 2'd2;
    localparam logic [1:0] PH_B    = 2'd3;

    localparam logic [SYNC_W-1:0] SYNC_IDLE_NIBBLE = 4'b1111;

    typedef enum logic {
        ST_IDLE = 1'b0,
        ST_RUN  = 1'b1
    } state_e;

    // The sync nibble {nVSYNC,nCLAMP,nHSYNC,nCSYNC} sits above the three colours.
    function automatic int sync_lsb(input int cw);
        return 3 * cw;
    endfunction

endpackage

// File: rtl/n64_vbus_tx_fifo.sv
// Small synchronous FIFO with valid/ready on both sides. Pointers carry one
// extra wrap bit so full and empty are told apart. A full FIFO still accepts a
// word when the reader takes one in the same cycle.
module n64_vbus_tx_fifo
#(
    parameter int width      = 25,
    parameter int depth_log2 = 1
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [width-1:0] in_data,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [width-1:0] out_data
);

    localparam int depth = 1 << depth_log2;
    localparam int pw    = depth_log2 + 1;

    logic [width-1:0] mem [depth];
    logic [pw-1:0]    wr_ptr;
    logic [pw-1:0]    rd_ptr;
    logic             armed;
    logic             full;
    logic             empty;
    logic             push;
    logic             pop;

    assign empty     = (wr_ptr == rd_ptr);
    assign full      = (wr_ptr[depth_log2] != rd_ptr[depth_log2]) &&
                       (wr_ptr[depth_log2-1:0] == rd_ptr[depth_log2-1:0]);
    assign out_valid = !empty;
    assign out_data  = mem[rd_ptr[depth_log2-1:0]];
    assign in_ready  = armed && (!full || out_ready);
    assign push      = in_valid && in_ready;
    assign pop       = out_valid && out_ready;

    // Pointer update; armed keeps in_ready low until the first clock after reset.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            armed  <= 1'b0;
        end else begin
            armed <= 1'b1;
            if (push) wr_ptr <= wr_ptr + pw'(1);
            if (pop)  rd_ptr <= rd_ptr + pw'(1);
        end
    end

    // Storage write; contents need no reset since the pointers gate visibility.
    always_ff @(posedge clk) begin
        if (push) mem[wr_ptr[depth_log2-1:0]] <= in_data;
    end

endmodule

// File: rtl/n64_vbus_tx.sv
// N64 video bus transmitter: sends one pixel per 4-cycle slot (SYNC, R, G, B)
// from a small input FIFO, substituting a blank pixel when the FIFO runs dry.
//
// state   | meaning
// ST_IDLE | bus parked (nVDSYNC=1, VD_o=0), phase held at SYNC, FIFO keeps filling
// ST_RUN  | slots streaming back to back, phase cycles SYNC->R->G->B
module n64_vbus_tx
    import n64_vbus_tx_pkg::*;
#(
    parameter int color_width     = COLOR_WIDTH_DEF,
    parameter int fifo_depth_log2 = 1
) (
    input  logic                       VCLK,
    input  logic                       nVRST,
    input  logic                       en,
    input  logic                       px_valid,
    output logic                       px_ready,
    input  logic [4+3*color_width-1:0] px_data,
    output logic                       nVDSYNC,
    output logic [color_width-1:0]     VD_o,
    output logic [7:0]                 underflow_cnt,
    output logic                       active
);

    localparam int dw = 4 + 3 * color_width;

    state_e                 state;
    state_e                 state_nxt;
    logic [1:0]             phase;
    logic [1:0]             phase_nxt;
    logic                   pop_req;
    logic                   fifo_valid;
    logic [dw-1:0]          fifo_data;
    logic [dw-1:0]          hold;
    logic                   nvdsync_nxt;
    logic [color_width-1:0] vd_nxt;

    n64_vbus_tx_fifo #(
        .width      (dw),
        .depth_log2 (fifo_depth_log2)
    ) u_fifo (
        .clk       (VCLK),
        .rst_n     (nVRST),
        .in_valid  (px_valid),
        .in_ready  (px_ready),
        .in_data   (px_data),
        .out_valid (fifo_valid),
        .out_ready (pop_req),
        .out_data  (fifo_data)
    );

    // Run state and slot phase registers.
    always_ff @(posedge VCLK or negedge nVRST) begin
        if (!nVRST) begin
            state <= ST_IDLE;
            phase <= PH_SYNC;
        end else begin
            state <= state_nxt;
            phase <= phase_nxt;
        end
    end

    // Next state, pop request and the bus value for the phase now in progress.
    always_comb begin
        state_nxt   = state;
        phase_nxt   = phase;
        pop_req     = 1'b0;
        nvdsync_nxt = 1'b1;
        vd_nxt      = '0;
        case (state)
            ST_IDLE: begin
                phase_nxt = PH_SYNC;
                if (en) begin
                    state_nxt = ST_RUN;
                    pop_req   = 1'b1;
                end
            end
            default: begin
                phase_nxt = phase + 2'd1;
                case (phase)
                    PH_SYNC: begin
                        nvdsync_nxt              = 1'b0;
                        vd_nxt[SYNC_W-1:0]       = hold[sync_lsb(color_width) +: SYNC_W];
                    end
                    PH_R:    vd_nxt = hold[2*color_width +: color_width];
                    PH_G:    vd_nxt = hold[color_width +: color_width];
                    default: vd_nxt = hold[0 +: color_width];
                endcase
                // Only fetch the next pixel if another slot will follow; a word
                // popped on the way out would otherwise be lost on restart.
                if (phase == PH_B) begin
                    if (en) pop_req   = 1'b1;
                    else    state_nxt = ST_IDLE;
                end
            end
        endcase
    end

    // Registered bus outputs, pixel holding register and underflow counter.
    // A start with an empty FIFO counts too: that slot goes out blank.
    always_ff @(posedge VCLK or negedge nVRST) begin
        if (!nVRST) begin
            nVDSYNC       <= 1'b1;
            VD_o          <= '0;
            active        <= 1'b0;
            underflow_cnt <= '0;
            hold          <= {SYNC_IDLE_NIBBLE, {(3*color_width){1'b0}}};
        end else begin
            nVDSYNC <= nvdsync_nxt;
            VD_o    <= vd_nxt;
            active  <= (state == ST_RUN);
            if (pop_req) begin
                if (fifo_valid) begin
                    hold <= fifo_data;
                end else begin
                    hold <= {hold[sync_lsb(color_width) +: SYNC_W], {(3*color_width){1'b0}}};
                    if (underflow_cnt != 8'hFF) underflow_cnt <= underflow_cnt + 8'd1;
                end
            end
        end
    end

endmodule
